// File: rtl/binary_morphology_pkg.sv
// binary_morphology_pkg: sequencer state IDs, filter modes and FSM encoding for the morphology stage
package binary_morphology_pkg;
   localparam logic [2:0] STATE_BOX_FILTER = 3'd1;
   localparam logic [2:0] STATE_MORPH      = 3'd2;
   localparam logic MODE_ERODE  = 1'b0;
   localparam logic MODE_DILATE = 1'b1;
   typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} morph_state_t;
endpackage

// File: rtl/binary_morphology_window_addr.sv
// morph_window_addr: 3x3 neighbour address for window tap kidx around pixel pos, clamped, with in-image flag
module morph_window_addr #(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8
) (
   input  logic [WIDTH_BITS+HEIGHT_BITS-1:0] pos,
   input  logic [3:0]                        kidx,
   output logic [WIDTH_BITS-1:0]             col,
   output logic [HEIGHT_BITS-1:0]            row,
   output logic                              in_range
);
   logic [1:0] kr, kc;
   logic signed [WIDTH_BITS+1:0]  nc;
   logic signed [HEIGHT_BITS+1:0] nr;
   // two extra bits hold the sign for -1 and the carry for WIDTH/HEIGHT
   always_comb begin
      kr = kidx >= 4'd6 ? 2'd2 : kidx >= 4'd3 ? 2'd1 : 2'd0;
      kc = 2'(kidx - {2'b00, kr} * 4'd3);
      nc = {2'b00, pos[WIDTH_BITS-1:0]} + {WIDTH_BITS'(0), kc} - (WIDTH_BITS+2)'(1);
      nr = {2'b00, pos[WIDTH_BITS+HEIGHT_BITS-1:WIDTH_BITS]} + {HEIGHT_BITS'(0), kr} - (HEIGHT_BITS+2)'(1);
      col = nc[WIDTH_BITS+1] ? '0 : nc[WIDTH_BITS] ? '1 : nc[WIDTH_BITS-1:0];
      row = nr[HEIGHT_BITS+1] ? '0 : nr[HEIGHT_BITS] ? '1 : nr[HEIGHT_BITS-1:0];
      in_range = ~|nc[WIDTH_BITS+1:WIDTH_BITS] & ~|nr[HEIGHT_BITS+1:HEIGHT_BITS];
   end
endmodule

// File: rtl/binary_morphology.sv
// binary_morphology: 3x3 erosion/dilation of a 1-bit image, one pixel per 10 cycles, stalls when not selected
module binary_morphology
   import binary_morphology_pkg::*;
#(
   parameter int WIDTH_BITS  = 8,
   parameter int HEIGHT_BITS = 8,
   parameter int WIDTH       = 2**WIDTH_BITS,
   parameter int HEIGHT      = 2**HEIGHT_BITS,
   parameter int STAGE_ID    = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [2:0]             global_state,
   input  logic                   mode,
   output logic [WIDTH_BITS-1:0]  oSrcCol,
   output logic [HEIGHT_BITS-1:0] oSrcRow,
   input  logic                   iSrcData,
   output logic [WIDTH_BITS-1:0]  oDstCol,
   output logic [HEIGHT_BITS-1:0] oDstRow,
   output logic                   oDstData,
   output logic                   oDstWren,
   output logic                   finished
);
   localparam int PB = WIDTH_BITS + HEIGHT_BITS;
   morph_state_t state;
   logic [PB-1:0] pos;
   logic [3:0] kidx;
   logic acc, latched_mode, in_range, active, sample, folded;
   morph_window_addr #(.WIDTH_BITS(WIDTH_BITS), .HEIGHT_BITS(HEIGHT_BITS)) u_addr (
      .pos(pos), .kidx(kidx), .col(oSrcCol), .row(oSrcRow), .in_range(in_range)
   );
   // off-image taps use the identity of the fold so edges are unaffected
   always_comb begin
      active = global_state == 3'(STAGE_ID);
      sample = in_range ? iSrcData : ~latched_mode;
      folded = kidx == 4'd0 ? sample : latched_mode == MODE_DILATE ? acc | sample : acc & sample;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pos <= '0;
         kidx <= '0;
         acc <= 1'b0;
         latched_mode <= 1'b0;
         oDstCol <= '0;
         oDstRow <= '0;
         oDstData <= 1'b0;
         oDstWren <= 1'b0;
         finished <= 1'b0;
      end else begin
         oDstWren <= 1'b0;
         case (state)
            IDLE: if (active && !finished) begin
               latched_mode <= mode;
               pos <= '0;
               kidx <= '0;
               state <= SCAN;
            end
            SCAN: if (active) begin
               acc <= folded;
               kidx <= kidx == 4'd8 ? 4'd0 : kidx + 4'd1;
               state <= kidx == 4'd8 ? WRITE : SCAN;
            end
            WRITE: if (active) begin
               oDstData <= acc;
               oDstCol <= pos[WIDTH_BITS-1:0];
               oDstRow <= pos[PB-1:WIDTH_BITS];
               oDstWren <= 1'b1;
               if (pos == PB'(WIDTH*HEIGHT-1)) begin
                  finished <= 1'b1;
                  state <= DONE;
               end else begin
                  pos <= pos + 1'b1;
                  kidx <= '0;
                  state <= SCAN;
               end
            end
            default: state <= DONE;
         endcase
      end
   end
endmodule

// File: tb/tb_binary_morphology.sv
// tb_binary_morphology: directed 4x4 frames against a reference morphology model with a write scoreboard
module tb_binary_morphology;
   import binary_morphology_pkg::*;
   typedef struct {int col; int row; int data; int cyc;} exp_t;
   logic clock = 1'b0, reset = 1'b1, mode = 1'b0;
   logic [2:0] global_state = 3'd0;
   logic [1:0] src_col, src_row, dst_col, dst_row;
   logic src_data, dst_data, dst_wren, finished;
   logic [15:0] img = 16'h0;
   exp_t sb[$];
   exp_t e_mon;
   int cyc = 0, compared = 0, mismatched = 0, fin_cyc;

   binary_morphology #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .STAGE_ID(2)) dut (
      .clock(clock), .reset(reset), .global_state(global_state), .mode(mode),
      .oSrcCol(src_col), .oSrcRow(src_row), .iSrcData(src_data),
      .oDstCol(dst_col), .oDstRow(dst_row), .oDstData(dst_data),
      .oDstWren(dst_wren), .finished(finished)
   );

   assign src_data = img[{src_row, src_col}];
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] model(logic [15:0] s, logic m);
      logic [15:0] r;
      logic a;
      int y, x;
      r = '0;
      for (int rr = 0; rr < 4; rr++)
         for (int cc = 0; cc < 4; cc++) begin
            a = ~m;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++) begin
                  y = rr + dr;
                  x = cc + dc;
                  if (y >= 0 && y < 4 && x >= 0 && x < 4)
                     a = m ? (a | s[y*4+x]) : (a & s[y*4+x]);
               end
            r[rr*4+cc] = a;
         end
      return r;
   endfunction

   // every write must match the head of the scoreboard, including its cycle
   always @(negedge clock) begin
      if (dst_wren) begin
         if (sb.size() == 0) check("unexpected_write", sb.size(), 1);
         else begin
            e_mon = sb.pop_front();
            check("wr_col", dst_col, e_mon.col);
            check("wr_row", dst_row, e_mon.row);
            check("wr_data", dst_data, e_mon.data);
            check("wr_cycle", cyc, e_mon.cyc);
         end
      end
   end

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      global_state = 3'd0;
      @(negedge clock);
      check("rst_wren", dst_wren, 0);
      check("rst_data", dst_data, 0);
      check("rst_dst_col", dst_col, 0);
      check("rst_dst_row", dst_row, 0);
      check("rst_src_col", src_col, 0);
      check("rst_src_row", src_row, 0);
      check("rst_finished", finished, 0);
      reset = 1'b0;
   endtask

   task automatic run_frame(logic [15:0] pic, logic m, int stall_at, int stall_len, int abort_at);
      logic [15:0] e;
      int a, n, t;
      e = model(pic, m);
      img = pic;
      @(negedge clock);
      mode = m;
      global_state = STATE_MORPH;
      a = cyc + 1;
      for (int k = 0; k < 16; k++) begin
         t = 10 * (k + 1);
         sb.push_back('{k % 4, k / 4, int'(e[k]), a + t + ((stall_len > 0 && t >= stall_at) ? stall_len : 0)});
      end
      fin_cyc = -1;
      for (int i = 0; i < 400 && fin_cyc < 0; i++) begin
         @(negedge clock);
         mode = ~m;
         n = cyc + 1 - a;
         if (abort_at > 0 && n == abort_at) begin
            reset = 1'b1;
            break;
         end
         global_state = (n >= stall_at && n < stall_at + stall_len) ? 3'd0 : STATE_MORPH;
         if (finished) fin_cyc = cyc;
      end
      if (abort_at == 0) begin
         check("finished_cycle", fin_cyc, a + 160 + stall_len);
         repeat (20) @(negedge clock);
         check("finished_sticky", finished, 1);
         check("sb_drained", sb.size(), 0);
      end
   endtask

   initial begin
      do_reset();
      run_frame(16'hFFFF, MODE_ERODE, 0, 0, 0);
      do_reset();
      run_frame(16'h0020, MODE_DILATE, 0, 0, 0);
      do_reset();
      run_frame(16'h0020, MODE_ERODE, 0, 0, 0);
      do_reset();
      run_frame(16'hFFFE, MODE_ERODE, 0, 0, 0);
      do_reset();
      run_frame(16'h0020, MODE_DILATE, 25, 7, 0);
      do_reset();
      run_frame(16'hFFFE, MODE_ERODE, 0, 0, 47);
      global_state = 3'd0;
      @(negedge clock);
      check("abort_wren", dst_wren, 0);
      check("abort_data", dst_data, 0);
      check("abort_dst_col", dst_col, 0);
      check("abort_dst_row", dst_row, 0);
      check("abort_finished", finished, 0);
      check("abort_pending", sb.size(), 12);
      sb.delete();
      reset = 1'b0;
      run_frame(16'hFFFE, MODE_ERODE, 0, 0, 0);
      do_reset();
      run_frame(16'($urandom), MODE_DILATE, 0, 0, 0);
      do_reset();
      run_frame(16'($urandom), MODE_ERODE, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
